// File: rtl/instr_memory_sync.sv
// Clocked instruction store: run-time loadable program RAM with a pipelined fetch port
// (READ_LAT 1 or 2). Define INSTR_PREDECODE_EN to add the registered instr_type output.
module instr_memory_sync #(
    parameter int INSTR_W  = 24,
    parameter int ADDR_W   = 24,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic               addr_err,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_busy,
    output logic [ADDR_W-1:0]  load_count
`ifdef INSTR_PREDECODE_EN
    ,
    output logic [1:0]         instr_type
`endif
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT    = (READ_LAT >= 2) ? 2 : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   ptr_r;
    logic [ADDR_W-1:0]   ptr_s;
    logic                wr_en_s;
    logic                accept_s;
    logic                in_range_s;
    logic [INSTR_W-1:0]  rd_word_s;
    logic [INSTR_W-1:0]  ram_r [DEPTH];

    logic                s0_v_r;
    logic [INSTR_W-1:0]  s0_d_r;
    logic                s0_e_r;
`ifdef INSTR_PREDECODE_EN
    logic [1:0]          s0_t_r;

    // Op field sits just below the 2-bit condition field at the top of the word.
    function automatic logic [1:0] predecode(input logic [INSTR_W-1:0] word, input logic err);
        logic [4:0] op;
        op = word[INSTR_W-3 -: 5];
        if (err) begin
            predecode = 2'b11;
        end else if (op <= 5'd6) begin
            predecode = 2'b00;
        end else if (op <= 5'd11) begin
            predecode = 2'b01;
        end else if (op <= 5'd14) begin
            predecode = 2'b10;
        end else begin
            predecode = 2'b11;
        end
    endfunction
`endif

    // Load FSM next state; the write pointer doubles as the load word count.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        wr_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_start) begin
                    state_s = ST_LOAD;
                    ptr_s   = {ADDR_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    ptr_s = {ADDR_W{1'b0}};
                end else if (load_valid && (ptr_r < DEPTH_A)) begin
                    wr_en_s = 1'b1;
                    ptr_s   = ptr_r + ADDR_W'(1);
                    if (load_last || (ptr_r == LAST_A)) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    ptr_s = ptr_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and write pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
        end
    end

    // Program RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram_r[ptr_r[RAM_AW-1:0]] <= load_data;
        end
    end

    // Fetch acceptance and RAM lookup; a load start wins over a same-cycle fetch.
    always_comb begin
        accept_s   = fetch_req && (state_r == ST_IDLE) && !load_start;
        in_range_s = (fetch_addr < DEPTH_A);
        rd_word_s  = in_range_s ? ram_r[fetch_addr[RAM_AW-1:0]] : {INSTR_W{1'b0}};
    end

    // First read stage: captures the word at acceptance so in-flight fetches see pre-load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_v_r <= 1'b0;
            s0_d_r <= {INSTR_W{1'b0}};
            s0_e_r <= 1'b0;
`ifdef INSTR_PREDECODE_EN
            s0_t_r <= 2'b11;
`endif
        end else begin
            s0_v_r <= accept_s;
            if (accept_s) begin
                s0_d_r <= rd_word_s;
                s0_e_r <= !in_range_s;
`ifdef INSTR_PREDECODE_EN
                s0_t_r <= predecode(rd_word_s, !in_range_s);
`endif
            end
        end
    end

    generate
        if (LAT == 2) begin : g_lat2
            logic               s1_v_r;
            logic [INSTR_W-1:0] s1_d_r;
            logic               s1_e_r;
`ifdef INSTR_PREDECODE_EN
            logic [1:0]         s1_t_r;
            assign instr_type = s1_t_r;
`endif

            // Second read stage; data holds between pulses.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_v_r <= 1'b0;
                    s1_d_r <= {INSTR_W{1'b0}};
                    s1_e_r <= 1'b0;
`ifdef INSTR_PREDECODE_EN
                    s1_t_r <= 2'b11;
`endif
                end else begin
                    s1_v_r <= s0_v_r;
                    if (s0_v_r) begin
                        s1_d_r <= s0_d_r;
                        s1_e_r <= s0_e_r;
`ifdef INSTR_PREDECODE_EN
                        s1_t_r <= s0_t_r;
`endif
                    end
                end
            end

            assign instr_valid = s1_v_r;
            assign instruction = s1_d_r;
            assign addr_err    = s1_e_r;
        end else begin : g_lat1
            assign instr_valid = s0_v_r;
            assign instruction = s0_d_r;
            assign addr_err    = s0_e_r;
`ifdef INSTR_PREDECODE_EN
            assign instr_type  = s0_t_r;
`endif
        end
    endgenerate

    assign fetch_ready = (state_r == ST_IDLE);
    assign load_busy   = (state_r == ST_LOAD);
    assign load_count  = ptr_r;

endmodule

// File: tb/tb_instr_memory_sync.sv
// Directed self-checking bench for instr_memory_sync (READ_LAT = 1, DEPTH = 256).
module tb_instr_memory_sync;

    localparam int INSTR_W = 24;
    localparam int ADDR_W  = 24;
    localparam int DEPTH   = 256;

    logic               clk = 1'b0;
    logic               reset;
    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               fetch_ready;
    logic               instr_valid;
    logic [INSTR_W-1:0] instruction;
    logic               addr_err;
    logic               load_start;
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;
    logic               load_busy;
    logic [ADDR_W-1:0]  load_count;
`ifdef INSTR_PREDECODE_EN
    logic [1:0]         instr_type;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [INSTR_W-1:0] wds [3];

    instr_memory_sync #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .READ_LAT(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .addr_err   (addr_err),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_busy  (load_busy),
        .load_count (load_count)
`ifdef INSTR_PREDECODE_EN
        ,
        .instr_type (instr_type)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_one(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] exp_w,
                             input logic exp_e, input string tag);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req  = 1'b0;
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_instr"}, {8'd0, instruction}, {8'd0, exp_w});
        check({tag, "_err"}, {31'd0, addr_err}, {31'd0, exp_e});
    endtask

    initial begin
        wds[0] = 24'h0044C0;
        wds[1] = 24'h06A180;
        wds[2] = 24'h0BC0AA;
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = 24'd0;
        load_start = 1'b0; load_valid = 1'b0; load_data = 24'd0; load_last = 1'b0;
        #2;
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", {8'd0, instruction}, 32'd0);
        check("rst_err", {31'd0, addr_err}, 32'd0);
        check("rst_ready", {31'd0, fetch_ready}, 32'd1);
        check("rst_busy", {31'd0, load_busy}, 32'd0);
        check("rst_count", {8'd0, load_count}, 32'd0);
`ifdef INSTR_PREDECODE_EN
        check("rst_type", {30'd0, instr_type}, 32'd3);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Fetch from an unloaded RAM at word 0.
        fetch_one(24'd0, 24'd0, 1'b0, "f0_empty");
        check("f0_ready", {31'd0, fetch_ready}, 32'd1);
        step();
        check("f0_pulse_end", {31'd0, instr_valid}, 32'd0);

        // Three-word load with load_last; concurrent fetch_req must be ignored.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("ld_busy", {31'd0, load_busy}, 32'd1);
        check("ld_ready", {31'd0, fetch_ready}, 32'd0);
        check("ld_count0", {8'd0, load_count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = wds[i];
            load_last  = (i == 2);
            fetch_req  = 1'b1;
            fetch_addr = 24'd0;
            step();
            check("ld_fetch_blocked", {31'd0, instr_valid}, 32'd0);
            check("ld_count", {8'd0, load_count}, i + 1);
        end
        load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
        check("ld_done_busy", {31'd0, load_busy}, 32'd0);
        check("ld_done_ready", {31'd0, fetch_ready}, 32'd1);

        // Back-to-back fetches of the loaded words.
        for (int i = 0; i < 3; i++) begin
            fetch_one(24'(i), wds[i], 1'b0, "f_seq");
`ifdef INSTR_PREDECODE_EN
            check("f_seq_type", {30'd0, instr_type}, 32'd0);
`endif
        end
        step();
        check("hold_valid", {31'd0, instr_valid}, 32'd0);
        check("hold_instr", {8'd0, instruction}, {8'd0, wds[2]});

        // Out-of-range fetches return NOOP with addr_err.
        fetch_one(24'd256, 24'd0, 1'b1, "oor256");
`ifdef INSTR_PREDECODE_EN
        check("oor_type", {30'd0, instr_type}, 32'd3);
`endif
        fetch_one(24'hFFFFFF, 24'd0, 1'b1, "oormax");
        fetch_one(24'd1, wds[1], 1'b0, "after_oor");

        // load_start beats a same-cycle fetch; restart inside LOAD clears the count.
        fetch_req = 1'b1; fetch_addr = 24'd1; load_start = 1'b1;
        step();
        fetch_req = 1'b0; load_start = 1'b0;
        check("race_valid", {31'd0, instr_valid}, 32'd0);
        check("race_busy", {31'd0, load_busy}, 32'd1);
        load_valid = 1'b1; load_data = 24'h111111;
        step();
        check("restart_pre", {8'd0, load_count}, 32'd1);
        load_valid = 1'b0; load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("restart_count", {8'd0, load_count}, 32'd0);
        check("restart_busy", {31'd0, load_busy}, 32'd1);
        load_valid = 1'b1; load_data = 24'h160000; load_last = 1'b1;
        step();
        load_valid = 1'b0; load_last = 1'b0;
        check("restart_done", {8'd0, load_count}, 32'd1);
        check("restart_idle", {31'd0, load_busy}, 32'd0);
        fetch_one(24'd0, 24'h160000, 1'b0, "restart_w0");
`ifdef INSTR_PREDECODE_EN
        check("itype_type", {30'd0, instr_type}, 32'd1);
`endif
        fetch_one(24'd1, wds[1], 1'b0, "restart_w1");

        // Overlong load: exits after word DEPTH-1, extra words dropped.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_valid = 1'b1;
            load_data  = 24'h100000 | 24'(i);
            step();
            if (i == DEPTH - 2) begin
                check("full_busy_254", {31'd0, load_busy}, 32'd1);
            end
            if (i == DEPTH - 1) begin
                check("full_exit", {31'd0, load_busy}, 32'd0);
            end
        end
        load_valid = 1'b0;
        check("full_count", {8'd0, load_count}, 32'd256);
        fetch_one(24'd255, 24'h1000FF, 1'b0, "full_w255");
        fetch_one(24'd0, 24'h100000, 1'b0, "full_w0");
        fetch_one(24'd1, 24'h100001, 1'b0, "full_w1");

        // Reset mid-load keeps written words.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 24'h0A0A0A;
        step();
        load_data = 24'h0B0B0B;
        step();
        load_valid = 1'b0;
        check("mid_busy", {31'd0, load_busy}, 32'd1);
        check("mid_count", {8'd0, load_count}, 32'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, load_busy}, 32'd0);
        check("mid_rst_count", {8'd0, load_count}, 32'd0);
        check("mid_rst_ready", {31'd0, fetch_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        fetch_one(24'd0, 24'h0A0A0A, 1'b0, "kept_w0");
        fetch_one(24'd1, 24'h0B0B0B, 1'b0, "kept_w1");
        fetch_one(24'd2, 24'h100002, 1'b0, "kept_w2");

        // Reset while a fetch pulse is outstanding cancels it.
        fetch_req = 1'b1; fetch_addr = 24'd1;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        check("inflight_pre", {31'd0, instr_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("inflight_cancel", {31'd0, instr_valid}, 32'd0);
        check("inflight_instr", {8'd0, instruction}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_idle", {31'd0, instr_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
